// File: rtl/y86_stage_reg.sv
// Y86-64 inter-stage pipeline register with stall/bubble control, a stall watchdog
// and saturating performance counters. Bubble takes priority over stall, and stall over load.
module y86_stage_reg #(
  parameter int DATA_W          = 64,
  parameter int CNT_W           = 16,
  parameter int STALL_LIMIT     = 255,
  parameter int BUBBLE_CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic              cnt_clr,
  input  logic [3:0]        in_stat,
  input  logic [3:0]        in_icode,
  input  logic              in_cnd,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [3:0]        in_dstE,
  input  logic [3:0]        in_dstM,
  output logic [3:0]        out_stat,
  output logic [3:0]        out_icode,
  output logic              out_cnd,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] out_valA,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM,
  output logic              out_is_bubble,
  output logic              ctl_err,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] S_AOK  = 4'h1;
  localparam int RUN_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]        stat_q, stat_d, icode_q, icode_d, dst_e_q, dst_e_d, dst_m_q, dst_m_d;
  logic              cnd_q, cnd_d, is_bubble_q, is_bubble_d;
  logic [DATA_W-1:0] val_e_q, val_e_d, val_a_q, val_a_d;
  logic              ctl_err_q, ctl_err_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              do_stall;

  // A simultaneous stall and bubble resolves to a bubble, so it is never a stall cycle.
  assign do_stall = stall & ~bubble;

  always_comb begin
    stat_d       = stat_q;
    icode_d      = icode_q;
    cnd_d        = cnd_q;
    val_e_d      = val_e_q;
    val_a_d      = val_a_q;
    dst_e_d      = dst_e_q;
    dst_m_d      = dst_m_q;
    is_bubble_d  = is_bubble_q;
    ctl_err_d    = ctl_err_q | (stall & bubble);
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    run_d        = run_q;

    if (bubble) begin
      stat_d      = S_AOK;
      icode_d     = I_NOP;
      dst_e_d     = R_NONE;
      dst_m_d     = R_NONE;
      is_bubble_d = 1'b1;
      if (BUBBLE_CLR_DATA != 0) begin
        cnd_d   = 1'b0;
        val_e_d = '0;
        val_a_d = '0;
      end else begin
        cnd_d   = in_cnd;
        val_e_d = in_valE;
        val_a_d = in_valA;
      end
    end else if (!stall) begin
      stat_d      = in_stat;
      icode_d     = in_icode;
      cnd_d       = in_cnd;
      val_e_d     = in_valE;
      val_a_d     = in_valA;
      dst_e_d     = in_dstE;
      dst_m_d     = in_dstM;
      is_bubble_d = 1'b0;
    end

    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
      run_d        = '0;
    end else begin
      if (do_stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (bubble && bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      if (!do_stall)            run_d = '0;
      else if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
    end

    // The watchdog trips on the edge where the run reaches the limit.
    timeout_d = cnt_clr ? 1'b0 : (timeout_q | (run_d == RUN_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q       <= S_AOK;
      icode_q      <= I_NOP;
      cnd_q        <= 1'b0;
      val_e_q      <= '0;
      val_a_q      <= '0;
      dst_e_q      <= R_NONE;
      dst_m_q      <= R_NONE;
      is_bubble_q  <= 1'b1;
      ctl_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      run_q        <= '0;
    end else begin
      stat_q       <= stat_d;
      icode_q      <= icode_d;
      cnd_q        <= cnd_d;
      val_e_q      <= val_e_d;
      val_a_q      <= val_a_d;
      dst_e_q      <= dst_e_d;
      dst_m_q      <= dst_m_d;
      is_bubble_q  <= is_bubble_d;
      ctl_err_q    <= ctl_err_d;
      timeout_q    <= timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      run_q        <= run_d;
    end
  end

  assign out_stat      = stat_q;
  assign out_icode     = icode_q;
  assign out_cnd       = cnd_q;
  assign out_valE      = val_e_q;
  assign out_valA      = val_a_q;
  assign out_dstE      = dst_e_q;
  assign out_dstM      = dst_m_q;
  assign out_is_bubble = is_bubble_q;
  assign ctl_err       = ctl_err_q;
  assign stall_timeout = timeout_q;
  assign stall_cnt     = stall_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule
